// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, status codes, register IDs,
// and the decode pipeline-register layout with its NOP bubble value.
package y86_pkg;

    localparam int WORD_W = 64;
    localparam int NREGS  = 15;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] SAOK = 4'h1;
    localparam logic [3:0] SHLT = 4'h2;
    localparam logic [3:0] SADR = 4'h3;
    localparam logic [3:0] SINS = 4'h4;

    localparam logic [3:0] RRSP  = 4'h4;
    localparam logic [3:0] RNONE = 4'hF;

    // Narrow fields of the D register; valC/valP are held separately so the
    // data width stays a module parameter.
    typedef struct packed {
        logic [3:0] stat;
        logic [3:0] icode;
        logic [3:0] ifun;
        logic [3:0] ra;
        logic [3:0] rb;
    } dctl_t;

    localparam dctl_t DCTL_NOP = '{stat: SAOK, icode: INOP, ifun: 4'h0,
                                   ra: RNONE, rb: RNONE};

endpackage

// File: rtl/regfile.sv
// Y86-64 program register file: two write ports (E, M with M winning on a
// collision), two combinational read ports, asynchronous clear.
module regfile
    import y86_pkg::*;
#(
    parameter int WORD_W = 64,
    parameter int NREGS  = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        wr_e_id,
    input  logic [WORD_W-1:0] wr_e_val,
    input  logic [3:0]        wr_m_id,
    input  logic [WORD_W-1:0] wr_m_val,
    input  logic [3:0]        rd_a_id,
    output logic [WORD_W-1:0] rd_a_val,
    input  logic [3:0]        rd_b_id,
    output logic [WORD_W-1:0] rd_b_val
);

    logic [NREGS-1:0][WORD_W-1:0] regs_q, regs_d;

    // Port M is applied last so popq %rsp keeps the loaded value.
    always_comb begin
        regs_d = regs_q;
        if (int'(wr_e_id) < NREGS) regs_d[wr_e_id] = wr_e_val;
        if (int'(wr_m_id) < NREGS) regs_d[wr_m_id] = wr_m_val;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) regs_q <= '0;
        else     regs_q <= regs_d;
    end

    assign rd_a_val = (int'(rd_a_id) < NREGS) ? regs_q[rd_a_id] : '0;
    assign rd_b_val = (int'(rd_b_id) < NREGS) ? regs_q[rd_b_id] : '0;

endmodule

// File: rtl/decode_stage.sv
// Y86-64 decode stage: F/D pipeline register, register file, source and
// destination selection, and valA/valB forwarding.
module decode_stage
    import y86_pkg::*;
#(
    parameter int WORD_W = 64,
    parameter int NREGS  = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        f_stat,
    input  logic [3:0]        f_icode,
    input  logic [3:0]        f_ifun,
    input  logic [3:0]        f_rA,
    input  logic [3:0]        f_rB,
    input  logic [WORD_W-1:0] f_valC,
    input  logic [WORD_W-1:0] f_valP,
    input  logic              D_stall,
    input  logic              D_bubble,
    input  logic [3:0]        e_dstE,
    input  logic [WORD_W-1:0] e_valE,
    input  logic [3:0]        M_dstE,
    input  logic [WORD_W-1:0] M_valE,
    input  logic [3:0]        M_dstM,
    input  logic [WORD_W-1:0] m_valM,
    input  logic [3:0]        W_dstE,
    input  logic [WORD_W-1:0] W_valE,
    input  logic [3:0]        W_dstM,
    input  logic [WORD_W-1:0] W_valM,
    output logic [3:0]        D_icode,
    output logic [3:0]        d_stat,
    output logic [3:0]        d_icode,
    output logic [3:0]        d_ifun,
    output logic [WORD_W-1:0] d_valC,
    output logic [WORD_W-1:0] d_valA,
    output logic [WORD_W-1:0] d_valB,
    output logic [3:0]        d_srcA,
    output logic [3:0]        d_srcB,
    output logic [3:0]        d_dstE,
    output logic [3:0]        d_dstM
);

    dctl_t             dctl_q, dctl_d;
    logic [WORD_W-1:0] valc_q, valc_d;
    logic [WORD_W-1:0] valp_q, valp_d;
    logic [WORD_W-1:0] rf_a, rf_b;

    // Stall outranks bubble: a stalled slot must keep its instruction.
    always_comb begin
        dctl_d = dctl_q;
        valc_d = valc_q;
        valp_d = valp_q;
        if (!D_stall) begin
            if (D_bubble) begin
                dctl_d = DCTL_NOP;
                valc_d = '0;
                valp_d = '0;
            end else begin
                dctl_d = '{stat: f_stat, icode: f_icode, ifun: f_ifun,
                           ra: f_rA, rb: f_rB};
                valc_d = f_valC;
                valp_d = f_valP;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dctl_q <= DCTL_NOP;
            valc_q <= '0;
            valp_q <= '0;
        end else begin
            dctl_q <= dctl_d;
            valc_q <= valc_d;
            valp_q <= valp_d;
        end
    end

    always_comb begin
        d_srcA = RNONE;
        d_srcB = RNONE;
        d_dstE = RNONE;
        d_dstM = RNONE;
        case (dctl_q.icode)
            IRRMOVQ, IRMMOVQ, IOPQ, IPUSHQ: d_srcA = dctl_q.ra;
            IRET, IPOPQ:                    d_srcA = RRSP;
            default: ;
        endcase
        case (dctl_q.icode)
            IRMMOVQ, IMRMOVQ, IOPQ:       d_srcB = dctl_q.rb;
            ICALL, IRET, IPUSHQ, IPOPQ:   d_srcB = RRSP;
            default: ;
        endcase
        case (dctl_q.icode)
            IRRMOVQ, IIRMOVQ, IOPQ:       d_dstE = dctl_q.rb;
            ICALL, IRET, IPUSHQ, IPOPQ:   d_dstE = RRSP;
            default: ;
        endcase
        case (dctl_q.icode)
            IMRMOVQ, IPOPQ:               d_dstM = dctl_q.ra;
            default: ;
        endcase
    end

    regfile #(.WORD_W(WORD_W), .NREGS(NREGS)) u_rf (
        .clk      (clk),
        .rst      (rst),
        .wr_e_id  (W_dstE),
        .wr_e_val (W_valE),
        .wr_m_id  (W_dstM),
        .wr_m_val (W_valM),
        .rd_a_id  (d_srcA),
        .rd_a_val (rf_a),
        .rd_b_id  (d_srcB),
        .rd_b_val (rf_b)
    );

    // Youngest producer first; RNONE never matches so it falls to the
    // register file, which reads RNONE as zero.
    always_comb begin
        d_valA = rf_a;
        if (dctl_q.icode == IJXX || dctl_q.icode == ICALL) d_valA = valp_q;
        else if (d_srcA != RNONE) begin
            if      (d_srcA == e_dstE) d_valA = e_valE;
            else if (d_srcA == M_dstM) d_valA = m_valM;
            else if (d_srcA == M_dstE) d_valA = M_valE;
            else if (d_srcA == W_dstM) d_valA = W_valM;
            else if (d_srcA == W_dstE) d_valA = W_valE;
        end
    end

    always_comb begin
        d_valB = rf_b;
        if (d_srcB != RNONE) begin
            if      (d_srcB == e_dstE) d_valB = e_valE;
            else if (d_srcB == M_dstM) d_valB = m_valM;
            else if (d_srcB == M_dstE) d_valB = M_valE;
            else if (d_srcB == W_dstM) d_valB = W_valM;
            else if (d_srcB == W_dstE) d_valB = W_valE;
        end
    end

    assign D_icode = dctl_q.icode;
    assign d_stat  = dctl_q.stat;
    assign d_icode = dctl_q.icode;
    assign d_ifun  = dctl_q.ifun;
    assign d_valC  = valc_q;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Decode stage of the Y86-64 pipeline, directly downstream of fetch.
- Contains:
  - the F/D pipeline register (D register), with stall and bubble control;
  - the 15-entry 64-bit program register file, written from the W stage;
  - the srcA/srcB/dstE/dstM selection logic;
  - the valA/valB forwarding muxes.
- Outputs feed the D/E pipeline register and the hazard control unit.

Parameters:
- WORD_W, 64, data/register width.
- NREGS, 15, number of program registers (IDs 0x0–0xE).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- f_stat  in  4  fetch status (1 AOK, 2 HLT, 3 ADR, 4 INS).
- f_icode, f_ifun, f_rA, f_rB  in  4 each  fetched instruction fields.
- f_valC, f_valP  in  64 each  constant word / next sequential PC from fetch.
- D_stall  in  1  hold the D register.
- D_bubble  in  1  load a NOP into the D register.
- e_dstE  in  4, e_valE  in  64  execute-stage result (after cmov condition).
- M_dstE  in  4, M_valE  in  64  memory-stage ALU result.
- M_dstM  in  4, m_valM  in  64  memory read data.
- W_dstE  in  4, W_valE  in  64  writeback ALU result; also register-file write port E.
- W_dstM  in  4, W_valM  in  64  writeback memory data; also register-file write port M.
- D_icode  out  4  registered icode (for hazard detection).
- d_stat, d_icode, d_ifun  out  4 each  pass-through to E.
- d_valC  out  64  pass-through constant.
- d_valA, d_valB  out  64 each  forwarded operand values.
- d_srcA, d_srcB, d_dstE, d_dstM  out  4 each  register IDs (0xF = RNONE).

Behaviour:
- D register (stat, icode, ifun, rA, rB, valC, valP):
  - Reset value: stat=1, icode=1 (NOP), ifun=0, rA=rB=0xF, valC=0, valP=0.
  - Bubble loads the reset value synchronously.
  - Stall holds the current value.
  - Stall has priority over bubble.
  - Otherwise loads f_* on each rising edge.
  - Latency from f_* to d_* is one cycle.
- Register file:
  - All 15 registers clear to 0 on reset.
  - Write port E: W_dstE/W_valE. Write port M: W_dstM/W_valM.
  - Writes occur on the rising edge; a write to ID 0xF is ignored.
  - If W_dstE == W_dstM (≠0xF), W_valM wins (popq %rsp case).
  - Reads are combinational, with no internal write-through; the W forwarding path covers same-cycle writes.
- d_srcA:
  - icode in {2,4,6,A} → rA;
  - icode in {9,B} → 4 (%rsp);
  - otherwise 0xF.
- d_srcB:
  - icode in {4,5,6} → rB;
  - icode in {8,9,A,B} → 4;
  - otherwise 0xF.
- d_dstE:
  - icode in {2,3,6} → rB;
  - icode in {8,9,A,B} → 4;
  - otherwise 0xF.
- d_dstM: icode in {5,B} → rA; otherwise 0xF.
- d_valA priority:
  1. icode in {7,8} → D valP.
  2. srcA == e_dstE → e_valE.
  3. == M_dstM → m_valM.
  4. == M_dstE → M_valE.
  5. == W_dstM → W_valM.
  6. == W_dstE → W_valE.
  7. Otherwise register file.
  - Forwarding matches only when srcA ≠ 0xF.
  - srcA == 0xF yields 0.
- d_valB: same chain on srcB, without the valP term.
- Pass-through: d_stat, d_icode, d_ifun and d_valC are D register contents; D_icode == d_icode.
- Other behaviour:
  - Reset asserted mid-operation clears the D register and the register file immediately; forwarding still operates from live bypass inputs.
  - icode values outside 0x0–0xB decode all IDs to 0xF; stat passes through unchanged.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants (IHALT 0 … IPOPQ B);
  - status codes (SAOK 1, SHLT 2, SADR 3, SINS 4);
  - RRSP 4 and RNONE 0xF;
  - the NOP bubble value.
- One sub-module: regfile (15×64, two write ports, two combinational read ports, asynchronous clear).
- The D register and the forwarding logic remain in decode_stage.

Test Plan:
- Reset, then reset release → all d_* show the NOP bubble value (d_icode=1, d_stat=1, IDs 0xF, d_valA=d_valB=0). Reading %rax via opq gives 0.
- Write W_dstE=3 with W_valE=0x1234, then present opq (6,0) with rA=3, rB=3 → d_valA=d_valB=0x1234 in the fetch-to-decode cycle (W forward); one cycle later the same values come from the register file.
- srcA=2 with e_dstE=2/e_valE=0xAA, M_dstM=2/m_valM=0xBB and W_dstE=2 all at once → d_valA=0xAA.
- Remove e_dstE → d_valA=0xBB.
- popq (B) with rA=4 → d_srcA=d_srcB=4, d_dstE=4, d_dstM=4. Then W_dstE=W_dstM=4 with W_valE=0x10 and W_valM=0x99 → register 4 reads 0x99.
- call (8) with valP=0x209 → d_valA=0x209, d_dstE=4, d_srcB=4.
- Assert D_stall for 2 cycles while f_* changes → d_* held. Then assert D_bubble → NOP. Then D_stall and D_bubble together → held. Assert rst mid-stream → d_icode=1 with no clock edge.
